// File: rtl/mux_pkg.sv
// Shared constants for the mux_4x1 selector.
// Select encodings and the default data width.
package mux_pkg;

  localparam int WIDTH_DEF = 1;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;
  localparam logic [1:0] SEL_I3 = 2'b11;

endpackage

// File: rtl/mux_2x1.sv
// Two-input selector leaf used to build the 4:1 tree.
// The ternary merges agreeing bits when s is X/Z.
module mux_2x1 #(
  parameter int WIDTH = 1
) (
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux_4x1.sv
// Four-input selector, sel = {s0,s1}, with a
// combinational output and an async-reset registered copy.
module mux_4x1
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  // s1 picks within each pair, s0 picks the pair
  mux_2x1 #(.WIDTH(WIDTH)) u_lo (
    .s (s1),
    .a (i0),
    .b (i1),
    .y (lo)
  );

  mux_2x1 #(.WIDTH(WIDTH)) u_hi (
    .s (s1),
    .a (i2),
    .b (i3),
    .y (hi)
  );

  mux_2x1 #(.WIDTH(WIDTH)) u_out (
    .s (s0),
    .a (lo),
    .b (hi),
    .y (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y_q <= '0;
    else     y_q <= y;
  end

endmodule

// File: tb/tb_mux_4x1.sv
// Directed self-checking bench for mux_4x1.
// Runs an 8-bit instance through the select/reset scenarios.
module tb_mux_4x1;
  import mux_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       s0, s1;
  logic [7:0] i0, i1, i2, i3;
  logic [7:0] y, y_q;

  int checks = 0;
  int failures = 0;

  mux_4x1 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .s0  (s0),
    .s1  (s1),
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .y   (y),
    .y_q (y_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input logic [1:0] sel);
    {s0, s1} = sel;
  endtask

  logic [7:0] sweep_exp [4];
  logic [7:0] prev;

  initial begin
    rst = 1'b1;
    set_sel(SEL_I0);
    i0 = 8'h00; i1 = 8'h00; i2 = 8'h00; i3 = 8'h00;
    @(posedge clk); #1;
    chk("reset_yq", y_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // all zero, sel 00
    #1 chk("zero_y", y, 8'h00);
    @(posedge clk); #1;
    chk("zero_yq", y_q, 8'h00);

    // i0 selected
    @(negedge clk);
    i0 = 8'h01;
    #1 chk("i0_y", y, 8'h01);
    chk("i0_yq_lag", y_q, 8'h00);
    @(posedge clk); #1;
    chk("i0_yq", y_q, 8'h01);

    // i1 selected, then bit-order confirmation
    @(negedge clk);
    i0 = 8'h00; i1 = 8'h01;
    s0 = 1'b0; s1 = 1'b1;
    #1 chk("i1_y", y, 8'h01);
    set_sel(SEL_I0);
    #1 chk("order_y", y, 8'h00);

    // i2 selected, i3 unselected toggled
    @(negedge clk);
    i1 = 8'h00; i2 = 8'h01;
    s0 = 1'b1; s1 = 1'b0;
    #1 chk("i2_y", y, 8'h01);
    i3 = 8'hFF;
    #1 chk("i2_unsel_y", y, 8'h01);
    @(posedge clk); #1;
    chk("i2_yq", y_q, 8'h01);

    // i3 selected, async reset between edges
    @(negedge clk);
    i2 = 8'h00; i3 = 8'h01;
    set_sel(SEL_I3);
    #1 chk("i3_y", y, 8'h01);
    @(posedge clk); #1;
    chk("i3_yq", y_q, 8'h01);
    #2 rst = 1'b1;
    #0.1;
    #1 chk("rst_async_yq", y_q, 8'h00);
    chk("rst_y", y, 8'h01);
    @(posedge clk); #1;
    chk("rst_hold_yq", y_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_rel_yq", y_q, 8'h00);
    @(posedge clk); #1;
    chk("rst_cap_yq", y_q, 8'h01);

    // 8-bit sweep with one-cycle lag on y_q
    @(negedge clk);
    i0 = 8'hA5; i1 = 8'h3C; i2 = 8'hFF; i3 = 8'h00;
    sweep_exp[0] = 8'hA5;
    sweep_exp[1] = 8'h3C;
    sweep_exp[2] = 8'hFF;
    sweep_exp[3] = 8'h00;
    prev = 8'h01;
    for (int k = 0; k < 4; k++) begin
      set_sel(2'(k));
      #1 chk($sformatf("sweep_y_%0d", k), y, sweep_exp[k]);
      chk($sformatf("sweep_lag_%0d", k), y_q, prev);
      @(posedge clk); #1;
      chk($sformatf("sweep_yq_%0d", k), y_q, sweep_exp[k]);
      prev = sweep_exp[k];
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
